// File: rtl/noc_pkg.sv
// Shared NoC definitions: port encodings, arbiter states and XY routing.
// Used by every router block that needs a direction decision.
package noc_pkg;

    localparam int ROUTE_W = 16;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // X is resolved first, then Y; all compares are unsigned.
    function automatic port_e xy_route(
        input logic [ROUTE_W-1:0] dx,
        input logic [ROUTE_W-1:0] dy,
        input logic [ROUTE_W-1:0] x,
        input logic [ROUTE_W-1:0] y
    );
        port_e p;
        if (dx > x)      p = PORT_E;
        else if (dx < x) p = PORT_W;
        else if (dy > y) p = PORT_N;
        else if (dy < y) p = PORT_S;
        else             p = PORT_L;
        return p;
    endfunction

endpackage

// File: rtl/input_port_vc_if.sv
// Upstream and downstream flit handshakes of one router input port.
// master drives flits in and accepts flits out; slave is the port.
interface input_port_vc_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        out_port;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_port
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_port
    );
endinterface

// File: rtl/vc_fifo.sv
// Single virtual-channel FIFO with first-word-fall-through head.
// Caller guarantees no write when full and no read when empty.
module vc_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       ocup
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;

    // Flit storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally at DEPTH; count tracks simultaneous push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_en)      cnt <= cnt + 1'b1;
            else if (!wr_en && rd_en) cnt <= cnt - 1'b1;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign ocup    = cnt;

endmodule

// File: rtl/input_port_vc.sv
// Router input port: XY-routed VC FIFOs with round-robin output grant.
// Optional INPUT_PORT_STATS_EN adds a saturating accepted-flit counter.
module input_port_vc
    import noc_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 32,
    parameter int NUM_VC   = 5,
    parameter int COORD_W  = 4,
    parameter int ROUTER_X = 0,
    parameter int ROUTER_Y = 0
) (
    input  logic clk,
    input  logic reset,
    input_port_vc_if.slave bus,
`ifdef INPUT_PORT_STATS_EN
    output logic [15:0] flit_cnt,
`endif
    output logic [NUM_VC*($clog2(DEPTH)+1)-1:0] vc_ocup
);

    localparam int OW = $clog2(DEPTH) + 1;
    localparam int VW = $clog2(NUM_VC);

    port_e             route;
    logic              accept;
    logic              pop;
    logic [NUM_VC-1:0] wr_en;
    logic [NUM_VC-1:0] rd_en;
    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] empty;
    logic [DATA_W-1:0] head [NUM_VC];

    arb_state_e        state_q, state_d;
    logic [VW-1:0]     ptr_q, ptr_d;
    logic [VW-1:0]     hold_q, hold_d;
    logic [VW-1:0]     grant;

    assign route = xy_route(
        ROUTE_W'(bus.in_data[DATA_W-1 -: COORD_W]),
        ROUTE_W'(bus.in_data[DATA_W-1-COORD_W -: COORD_W]),
        ROUTE_W'(ROUTER_X),
        ROUTE_W'(ROUTER_Y));

    assign bus.in_ready = !full[route];
    assign accept       = bus.in_valid && bus.in_ready;

    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        assign wr_en[i] = accept && (int'(route) == i);
        assign rd_en[i] = pop && (int'(grant) == i);

        vc_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (reset),
            .wr_en   (wr_en[i]),
            .wr_data (bus.in_data),
            .rd_en   (rd_en[i]),
            .rd_data (head[i]),
            .full    (full[i]),
            .empty   (empty[i]),
            .ocup    (vc_ocup[i*OW +: OW])
        );
    end

    // Round-robin pick from the pointer upward; a locked grant overrides.
    always_comb begin
        logic found;
        int   j;
        grant = ptr_q;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_VC; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_VC) j = j - NUM_VC;
            if (!found && !empty[j]) begin
                grant = VW'(j);
                found = 1'b1;
            end
        end
        if (state_q == HOLD) grant = hold_q;
    end

    assign bus.out_valid = (|(~empty)) || (state_q == HOLD);
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_data  = bus.out_valid ? head[grant] : '0;
    assign bus.out_port  = bus.out_valid ? 3'(grant) : 3'd0;

    // Lock a stalled grant so the offered flit stays stable; advance on pop.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ARB: begin
                if (bus.out_valid && !bus.out_ready) begin
                    state_d = HOLD;
                    hold_d  = grant;
                end
            end
            HOLD: begin
                if (bus.out_ready) state_d = ARB;
            end
        endcase
        if (pop) begin
            if (int'(grant) == NUM_VC - 1) ptr_d = '0;
            else                           ptr_d = grant + 1'b1;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

`ifdef INPUT_PORT_STATS_EN
    // Count accepted flits, sticking at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            flit_cnt <= '0;
        else if (accept && flit_cnt != '1)     flit_cnt <= flit_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_input_port_vc.sv
// Directed bench for input_port_vc at router (2,2), 16-bit flits.
// Flit = {dest_x[3:0], dest_y[3:0], payload[7:0]}.
module tb_input_port_vc;

    localparam int DW = 16;
    localparam int OW = 6;
    localparam int NV = 5;

    logic clk = 1'b0;
    logic reset;
    logic [NV*OW-1:0] vc_ocup;
`ifdef INPUT_PORT_STATS_EN
    logic [15:0] flit_cnt;
`endif

    int tests  = 0;
    int failed = 0;

    // Destination of each output port from router (2,2): N,S,E,W,L.
    int px [NV] = '{2, 2, 3, 1, 2};
    int py [NV] = '{3, 1, 2, 2, 2};

    always #5 clk = ~clk;

    input_port_vc_if #(.DATA_W(DW)) bus ();

    input_port_vc #(
        .DATA_W   (DW),
        .DEPTH    (32),
        .NUM_VC   (NV),
        .COORD_W  (4),
        .ROUTER_X (2),
        .ROUTER_Y (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
`ifdef INPUT_PORT_STATS_EN
        .flit_cnt (flit_cnt),
`endif
        .vc_ocup  (vc_ocup)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] flit(input int p, input logic [7:0] pl);
        return {4'(px[p]), 4'(py[p]), pl};
    endfunction

    function automatic logic [31:0] occ(input int v);
        return 32'(vc_ocup[v*OW +: OW]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int order [NV];
        int n;
        order = '{2, 3, 0, 1, 4};

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_port", bus.out_port, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_vc_ocup", vc_ocup, 0);
        chk("rst_in_ready", bus.in_ready, 1);
`ifdef INPUT_PORT_STATS_EN
        chk("rst_flit_cnt", flit_cnt, 0);
`endif
        reset = 1'b1;
        step();

        // XY routing, one flit per direction, latency one cycle.
        bus.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = flit(order[i], 8'(i + 1));
            #1;
            chk("route_in_ready", bus.in_ready, 1);
            chk("route_pre_valid", bus.out_valid, 0);
            step();
            bus.in_valid = 1'b0;
            #1;
            chk("route_valid", bus.out_valid, 1);
            chk("route_port", bus.out_port, order[i]);
            chk("route_data", bus.out_data, flit(order[i], 8'(i + 1)));
            step();
            chk("route_drained", bus.out_valid, 0);
        end

        // Fill the E VC with the output stalled.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = flit(2, 8'(i));
            step();
        end
        bus.in_data = flit(2, 8'hEE);
        #1;
        chk("full_e_ready", bus.in_ready, 0);
        chk("full_e_ocup", occ(2), 32);
        bus.in_data = flit(0, 8'h0A);
        #1;
        chk("full_n_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("full_n_ocup", occ(0), 1);
        chk("full_e_ocup2", occ(2), 32);
        chk("full_hold_port", bus.out_port, 2);
        chk("full_hold_data", bus.out_data, flit(2, 8'h00));

        // Full VC stays not-ready even while being popped.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = flit(2, 8'hEE);
        #1;
        chk("full_pop_ready", bus.in_ready, 0);
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("full_pop_ocup", occ(2), 31);
        chk("rr_port_n", bus.out_port, 0);
        chk("rr_data_n", bus.out_data, flit(0, 8'h0A));
        step();
        chk("rr_port_e", bus.out_port, 2);
        chk("rr_data_e", bus.out_data, flit(2, 8'h01));
        n = 0;
        while (bus.out_valid && n < 100) begin
            step();
            n++;
        end
        chk("drain_valid", bus.out_valid, 0);
        chk("drain_ocup", vc_ocup, 0);

        // Same-cycle write and pop on one VC.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = flit(2, 8'hA0);
        step();
        bus.in_data   = flit(2, 8'hA1);
        bus.out_ready = 1'b1;
        #1;
        chk("wp_ready", bus.in_ready, 1);
        chk("wp_ocup_pre", occ(2), 1);
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("wp_ocup", occ(2), 1);
        chk("wp_data", bus.out_data, flit(2, 8'hA1));
        step();
        chk("wp_empty", bus.out_valid, 0);

        // Two flits per VC drain in round-robin order.
        bus.out_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < NV; p++) begin
                bus.in_valid = 1'b1;
                bus.in_data  = flit(p, 8'(16 * r + p));
                step();
            end
        end
        bus.in_valid = 1'b0;
        #1;
        chk("rr_ocup_l", occ(4), 2);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("rr_valid", bus.out_valid, 1);
            chk("rr_port", bus.out_port, k % 5);
            chk("rr_data", bus.out_data, flit(k % 5, 8'(16 * (k / 5) + k % 5)));
            step();
        end
        chk("rr_done", bus.out_valid, 0);

        // Locked grant on VC 2 while VC 1 fills with pointer at 1.
        bus.in_valid = 1'b1;
        bus.in_data  = flit(0, 8'h33);
        step();
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = flit(2, 8'h55);
        step();
        bus.in_data = flit(1, 8'h11);
        #1;
        chk("lock_port0", bus.out_port, 2);
        step();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("lock_port", bus.out_port, 2);
            chk("lock_data", bus.out_data, flit(2, 8'h55));
            step();
        end
        chk("lock_s_ocup", occ(1), 1);
        bus.out_ready = 1'b1;
        #1;
        chk("lock_rel_port", bus.out_port, 2);
        step();
        chk("after_port", bus.out_port, 1);
        chk("after_data", bus.out_data, flit(1, 8'h11));
        step();
        chk("after_empty", bus.out_valid, 0);

        // Reset mid-burst drops everything immediately.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = flit(i % 5, 8'(i));
            step();
        end
        bus.in_valid = 1'b0;
        #1;
        chk("burst_valid", bus.out_valid, 1);
        chk("burst_ocup_w", occ(3), 2);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_ocup", vc_ocup, 0);
        chk("mid_rst_port", bus.out_port, 0);
        chk("mid_rst_data", bus.out_data, 0);
        chk("mid_rst_ready", bus.in_ready, 1);
`ifdef INPUT_PORT_STATS_EN
        chk("mid_rst_cnt", flit_cnt, 0);
`endif
        step();
        reset = 1'b1;
        step();
        chk("post_rst_valid", bus.out_valid, 0);

`ifdef INPUT_PORT_STATS_EN
        // Counter saturates after more than 65535 accepted flits.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = flit(4, 8'h77);
        step();
        step();
        step();
        chk("cnt_three", flit_cnt, 3);
        repeat (69997) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("cnt_sat", flit_cnt, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
